// File: rtl/wavefront_scheduler.sv
// Wavefront issue scheduler: round-robin grant of eligible wave slots with
// clause locking, a held valid/ready grant, and barrier release pulses.
module wavefront_scheduler #(
  parameter int NUM_WAVES = 4,
  parameter int WID_W     = $clog2(NUM_WAVES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WAVES-1:0] wave_active,
  input  logic [NUM_WAVES-1:0] wave_barrier,
  input  logic [NUM_WAVES-1:0] wave_clause,
  input  logic [NUM_WAVES-1:0] wave_stall,
  output logic                 issue_valid,
  output logic [WID_W-1:0]     issue_wave_id,
  input  logic                 issue_ready,
  output logic [NUM_WAVES-1:0] barrier_release,
  output logic                 all_idle
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                state_r;
  logic [WID_W-1:0]      rr_ptr_r;
  logic                  lock_valid_r;
  logic [WID_W-1:0]      lock_id_r;

  logic [NUM_WAVES-1:0]  eligible_s;
  logic                  handshake_s;
  logic                  barrier_done_s;
  logic                  lock_hold_s;
  logic [WID_W-1:0]      lock_id_s;
  logic [WID_W-1:0]      rr_base_s;
  logic [WID_W-1:0]      cand_s;
  logic                  grant_found_s;
  logic [WID_W-1:0]      grant_id_s;

  assign eligible_s     = wave_active & ~wave_barrier & ~wave_stall;
  // issue_valid is only ever high in ST_ISSUE, so it alone qualifies the handshake.
  assign handshake_s    = issue_valid & issue_ready;
  assign barrier_done_s = (|(wave_active & wave_barrier)) & ~(|(wave_active & ~wave_barrier));
  // A handshake moves the pointer to the accepted slot; arbitrating in the same
  // cycle must already search from there to allow back-to-back issue.
  assign rr_base_s      = handshake_s ? issue_wave_id : rr_ptr_r;

  // Lock seen by this cycle's arbitration: a clause handshake locks immediately,
  // and an existing lock drops as soon as its slot leaves the clause or goes inactive.
  always_comb begin
    lock_id_s   = lock_id_r;
    lock_hold_s = 1'b0;
    if (handshake_s) begin
      lock_id_s   = issue_wave_id;
      lock_hold_s = wave_clause[issue_wave_id] & wave_active[issue_wave_id];
    end else begin
      lock_id_s   = lock_id_r;
      lock_hold_s = lock_valid_r & wave_clause[lock_id_r] & wave_active[lock_id_r];
    end
  end

  // Round-robin search starting after rr_base_s; a held lock restricts the choice to the locked slot.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    cand_s        = '0;
    if (lock_hold_s) begin
      grant_found_s = eligible_s[lock_id_s];
      grant_id_s    = lock_id_s;
    end else begin
      for (int k = 1; k <= NUM_WAVES; k++) begin
        cand_s        = WID_W'((int'(rr_base_s) + k) % NUM_WAVES);
        grant_id_s    = (!grant_found_s && eligible_s[cand_s]) ? cand_s : grant_id_s;
        grant_found_s = grant_found_s | eligible_s[cand_s];
      end
    end
  end

  // Scheduler state machine with registered grant, release pulse and idle flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      issue_valid     <= 1'b0;
      issue_wave_id   <= '0;
      barrier_release <= '0;
      lock_valid_r    <= 1'b0;
      lock_id_r       <= '0;
      rr_ptr_r        <= WID_W'(NUM_WAVES - 1);
      all_idle        <= 1'b1;
    end else begin
      all_idle <= ~(|wave_active);
      case (state_r)
        ST_IDLE: begin
          if (barrier_done_s) begin
            state_r         <= ST_RELEASE;
            issue_valid     <= 1'b0;
            barrier_release <= wave_active & wave_barrier;
            lock_valid_r    <= 1'b0;
          end else begin
            barrier_release <= '0;
            lock_valid_r    <= lock_hold_s;
            lock_id_r       <= lock_id_s;
            if (grant_found_s) begin
              state_r       <= ST_ISSUE;
              issue_valid   <= 1'b1;
              issue_wave_id <= grant_id_s;
            end else begin
              state_r       <= ST_IDLE;
              issue_valid   <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          barrier_release <= '0;
          lock_valid_r    <= lock_hold_s;
          lock_id_r       <= lock_id_s;
          if (handshake_s) begin
            // While locked the accepted slot already equals rr_ptr_r, so this
            // assignment leaves the pointer unchanged during a clause.
            rr_ptr_r <= issue_wave_id;
            if (grant_found_s) begin
              state_r       <= ST_ISSUE;
              issue_valid   <= 1'b1;
              issue_wave_id <= grant_id_s;
            end else begin
              state_r       <= ST_IDLE;
              issue_valid   <= 1'b0;
            end
          end else begin
            state_r     <= ST_ISSUE;
            issue_valid <= 1'b1;
          end
        end
        ST_RELEASE: begin
          state_r         <= ST_IDLE;
          issue_valid     <= 1'b0;
          barrier_release <= '0;
          lock_valid_r    <= 1'b0;
        end
        default: begin
          state_r         <= ST_IDLE;
          issue_valid     <= 1'b0;
          barrier_release <= '0;
          lock_valid_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule
